// File: rtl/ldl_bin2hot_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ldl_bin2hot_pkg : mode constants and the binary-to-vector decode function
// Revision 1.0
// ---------------------------------------------------------------------------
package ldl_bin2hot_pkg;

  localparam logic MODE_ONEHOT = 1'b0;
  localparam logic MODE_THERM  = 1'b1;

  // Upper bound on N; callers slice {err, vec[N-1:0]} out of the wide result.
  localparam int unsigned MAX_N = 1024;

  // Returns {err, vec}: err sits at bit MAX_N, vec in [MAX_N-1:0].
  function automatic logic [MAX_N:0] decode(
    input logic        en,
    input logic        mode,
    input logic [31:0] bin,
    input int unsigned n
  );
    logic [MAX_N:0]   res;
    logic [MAX_N-1:0] one;
    res = '0;
    one = MAX_N'(1);
    if (en) begin
      if (bin >= n) begin
        res[MAX_N] = 1'b1;
      end else begin
        unique case (mode)
          MODE_ONEHOT: res[MAX_N-1:0] = one << bin;
          MODE_THERM:  res[MAX_N-1:0] = ((one << bin) << 1) - one;
          default:     res[MAX_N-1:0] = '0;
        endcase
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ldl_skid_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ldl_skid_buf : two-entry valid/ready buffer (main output register + skid)
// Revision 1.0
// ---------------------------------------------------------------------------
module ldl_skid_buf #(
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic              rdy_q, rdy_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              acc;
  logic              drain;

  assign acc   = in_valid && rdy_q;
  assign drain = main_vld_q && out_ready;

  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (drain && skid_vld_q) begin
      // Skid moves forward; a same-cycle accept refills the skid.
      main_d     = skid_q;
      skid_vld_d = acc;
      if (acc) begin
        skid_d = in_data;
      end
    end else if (!main_vld_q || drain) begin
      main_vld_d = acc;
      if (acc) begin
        main_d = in_data;
      end
    end else if (acc) begin
      skid_vld_d = 1'b1;
      skid_d     = in_data;
    end
    // Registered ready keeps out_ready off the in_ready timing path.
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;

endmodule
`default_nettype wire

// File: rtl/ldl_bin2hot_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ldl_bin2hot_pipe : registered one-hot / thermometer decoder with skid output
// Revision 1.0
// ---------------------------------------------------------------------------
module ldl_bin2hot_pipe
  import ldl_bin2hot_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_en,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_vec,
  output logic             out_err
);

  logic [MAX_N:0] dec_full;
  logic [N:0]     dec_data;
  logic [N:0]     buf_data;

  assign dec_full = decode(in_en, in_mode, 32'(in_bin), N);
  assign dec_data = {dec_full[MAX_N], dec_full[N-1:0]};

  // Vector bits above N are always zero once bin >= N is flagged as an error.
  generate
    if (N < MAX_N) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^dec_full[MAX_N-1:N];
    end
  endgenerate

  ldl_skid_buf #(
    .DATA_W(N + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_data)
  );

  assign out_vec = buf_data[N-1:0];
  assign out_err = buf_data[N];

endmodule
`default_nettype wire
